// File: rtl/tx_arbiter_if.sv
// tx_arbiter_if: requester and UART-transmitter signal bundle for tx_arbiter.
// master = environment side (requesters and UART), slave = arbiter side.
interface tx_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_byte;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_byte;
    logic       req1_last;
    logic       req1_ready;
    logic       tx_ready;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic [1:0] grant;
    logic       busy;

    modport master (
        output req0_valid, req0_byte, req0_last,
        output req1_valid, req1_byte, req1_last,
        output tx_ready,
        input  req0_ready, req1_ready,
        input  tx_dv, tx_byte, grant, busy
    );

    modport slave (
        input  req0_valid, req0_byte, req0_last,
        input  req1_valid, req1_byte, req1_last,
        input  tx_ready,
        output req0_ready, req1_ready,
        output tx_dv, tx_byte, grant, busy
    );
endinterface

// File: rtl/tx_arbiter.sv
// tx_arbiter: two-requester, round-robin, message-locked byte arbiter feeding
// a UART transmitter. A grant is held for a whole message (until a byte with
// last=1) or until MAX_BURST bytes have been sent, whichever comes first.
// Optional feature: define TX_ARBITER_CRLF_EN to append 8'h0D, 8'h0A after
// every completed message (not after a forced MAX_BURST release).
module tx_arbiter #(
    parameter int MAX_BURST = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    tx_arbiter_if.slave  bus
);

    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_LOAD        = 3'd1,
        S_WAIT_ACCEPT = 3'd2,
        S_WAIT_IDLE   = 3'd3
`ifdef TX_ARBITER_CRLF_EN
        ,
        S_CR          = 3'd4,
        S_LF          = 3'd5
`endif
    } state_t;

    state_t     state_q;
    logic [1:0] grant_q;
    logic       tx_dv_q;
    logic [7:0] tx_byte_q;
    logic       last_q;
    logic [7:0] burst_q;
    logic       last_owner_q;   // 0 = req0 served last, 1 = req1 served last
`ifdef TX_ARBITER_CRLF_EN
    logic [1:0] crlf_phase_q;   // 0 = data, 1 = CR sent, 2 = LF sent
`endif

    logic [1:0] grant_d;
    logic       sel_valid;
    logic [7:0] sel_byte;
    logic       sel_last;
    logic       release_d;
    logic       reload_d;
`ifdef TX_ARBITER_CRLF_EN
    logic       send_cr_d;
    logic       send_lf_d;
`endif

    // Round-robin pick among valid requesters; ties go to the one not served last.
    always_comb begin
        grant_d = 2'b00;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_d = last_owner_q ? 2'b01 : 2'b10;
        end else if (bus.req0_valid) begin
            grant_d = 2'b01;
        end else if (bus.req1_valid) begin
            grant_d = 2'b10;
        end
    end

    // Mux the offer of the currently granted requester.
    always_comb begin
        sel_valid = 1'b0;
        sel_byte  = 8'h00;
        sel_last  = 1'b0;
        if (grant_q[0]) begin
            sel_valid = bus.req0_valid;
            sel_byte  = bus.req0_byte;
            sel_last  = bus.req0_last;
        end else if (grant_q[1]) begin
            sel_valid = bus.req1_valid;
            sel_byte  = bus.req1_byte;
            sel_last  = bus.req1_last;
        end
    end

    // Decide what happens when the UART goes idle again after a byte.
    always_comb begin
        release_d = 1'b0;
        reload_d  = 1'b0;
`ifdef TX_ARBITER_CRLF_EN
        send_cr_d = 1'b0;
        send_lf_d = 1'b0;
`endif
        if (state_q == S_WAIT_IDLE && bus.tx_ready) begin
            if (last_q) begin
`ifdef TX_ARBITER_CRLF_EN
                case (crlf_phase_q)
                    2'd0:    send_cr_d = 1'b1;
                    2'd1:    send_lf_d = 1'b1;
                    default: release_d = 1'b1;
                endcase
`else
                release_d = 1'b1;
`endif
            end else if (burst_q == MAX_BURST_C) begin
                release_d = 1'b1;
            end else begin
                reload_d = 1'b1;
            end
        end
    end

    // Main arbiter FSM with registered UART-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            grant_q      <= 2'b00;
            tx_dv_q      <= 1'b0;
            tx_byte_q    <= 8'h00;
            last_q       <= 1'b0;
            burst_q      <= 8'd0;
            last_owner_q <= 1'b1;
`ifdef TX_ARBITER_CRLF_EN
            crlf_phase_q <= 2'd0;
`endif
        end else begin
            tx_dv_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.tx_ready && (grant_d != 2'b00)) begin
                        grant_q <= grant_d;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Grant stays locked here until the owner offers its next byte.
                    if (sel_valid) begin
                        tx_byte_q <= sel_byte;
                        last_q    <= sel_last;
                        burst_q   <= burst_q + 8'd1;
                        tx_dv_q   <= 1'b1;
                        state_q   <= S_WAIT_ACCEPT;
                    end
                end
                S_WAIT_ACCEPT: begin
                    if (!bus.tx_ready) begin
                        state_q <= S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (release_d) begin
                        grant_q      <= 2'b00;
                        last_owner_q <= grant_q[1];
                        burst_q      <= 8'd0;
                        last_q       <= 1'b0;
                        state_q      <= S_IDLE;
`ifdef TX_ARBITER_CRLF_EN
                        crlf_phase_q <= 2'd0;
                    end else if (send_cr_d) begin
                        state_q <= S_CR;
                    end else if (send_lf_d) begin
                        state_q <= S_LF;
`endif
                    end else if (reload_d) begin
                        state_q <= S_LOAD;
                    end
                end
`ifdef TX_ARBITER_CRLF_EN
                S_CR: begin
                    tx_byte_q    <= 8'h0D;
                    tx_dv_q      <= 1'b1;
                    crlf_phase_q <= 2'd1;
                    state_q      <= S_WAIT_ACCEPT;
                end
                S_LF: begin
                    tx_byte_q    <= 8'h0A;
                    tx_dv_q      <= 1'b1;
                    crlf_phase_q <= 2'd2;
                    state_q      <= S_WAIT_ACCEPT;
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    assign bus.req0_ready = (state_q == S_LOAD) && grant_q[0];
    assign bus.req1_ready = (state_q == S_LOAD) && grant_q[1];
    assign bus.tx_dv      = tx_dv_q;
    assign bus.tx_byte    = tx_byte_q;
    assign bus.grant      = grant_q;
    assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed bench for tx_arbiter with queue-driven requesters
// and a UART model that drops tx_ready one cycle after each strobe for 10 cycles.
module tb_tx_arbiter;

    logic clk;
    logic rst_n;
    logic uart_rdy;
    logic hold_low;

    tx_arbiter_if bus ();

    tx_arbiter #(.MAX_BURST(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.tx_ready = uart_rdy && !hold_low;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [7:0] cap_b[$];
    logic [1:0] cap_g[$];
    logic [7:0] exp_b[$];
    logic [1:0] exp_g[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Requester 0: offers queue head, pops it after an accepting edge.
    initial begin : drv0
        bit acc;
        acc = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req0_byte  = 8'h00;
        bus.req0_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (acc && q0.size() > 0) q0.delete(0);
            if (q0.size() > 0) begin
                bus.req0_valid = 1'b1;
                bus.req0_byte  = q0[0][7:0];
                bus.req0_last  = q0[0][8];
            end else begin
                bus.req0_valid = 1'b0;
                bus.req0_byte  = 8'h00;
                bus.req0_last  = 1'b0;
            end
            acc = bus.req0_valid && bus.req0_ready;
        end
    end

    // Requester 1: same behaviour as requester 0.
    initial begin : drv1
        bit acc;
        acc = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req1_byte  = 8'h00;
        bus.req1_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (acc && q1.size() > 0) q1.delete(0);
            if (q1.size() > 0) begin
                bus.req1_valid = 1'b1;
                bus.req1_byte  = q1[0][7:0];
                bus.req1_last  = q1[0][8];
            end else begin
                bus.req1_valid = 1'b0;
                bus.req1_byte  = 8'h00;
                bus.req1_last  = 1'b0;
            end
            acc = bus.req1_valid && bus.req1_ready;
        end
    end

    // UART model: busy for 10 cycles starting one cycle after each tx_dv.
    initial begin : uart
        uart_rdy = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.tx_dv === 1'b1) begin
                @(negedge clk);
                uart_rdy = 1'b0;
                repeat (10) @(negedge clk);
                uart_rdy = 1'b1;
            end
        end
    end

    // Capture every strobed byte with the grant seen at that moment.
    initial begin : mon
        forever begin
            @(negedge clk);
            if (bus.tx_dv === 1'b1) begin
                cap_b.push_back(bus.tx_byte);
                cap_g.push_back(bus.grant);
            end
        end
    end

    task automatic clear_all();
        cap_b.delete();
        cap_g.delete();
        exp_b.delete();
        exp_g.delete();
    endtask

    task automatic exp_add(input logic [7:0] b, input logic [1:0] g);
        exp_b.push_back(b);
        exp_g.push_back(g);
    endtask

    // A completed message is followed by CR, LF under the same grant when enabled.
    task automatic exp_end();
`ifdef TX_ARBITER_CRLF_EN
        logic [1:0] g;
        g = exp_g[exp_g.size() - 1];
        exp_b.push_back(8'h0D);
        exp_g.push_back(g);
        exp_b.push_back(8'h0A);
        exp_g.push_back(g);
`endif
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cap_b.size() >= exp_b.size() && bus.busy === 1'b0 && uart_rdy === 1'b1
                && q0.size() == 0 && q1.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        repeat (3) @(negedge clk);
        while (uart_rdy !== 1'b1) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.grant !== 2'b00) begin n_bad++; $display("FAIL reset_grant: got %b want 00", bus.grant); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.tx_dv !== 1'b0) begin n_bad++; $display("FAIL reset_tx_dv: got %b want 0", bus.tx_dv); end
        n_cmp++; if (bus.tx_byte !== 8'h00) begin n_bad++; $display("FAIL reset_tx_byte: got %h want 00", bus.tx_byte); end
        n_cmp++; if (bus.req0_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req0_ready: got %b want 0", bus.req0_ready); end
        n_cmp++; if (bus.req1_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req1_ready: got %b want 0", bus.req1_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_msg();
        bit ok;
        clear_all();
        exp_add(8'h41, 2'b01); exp_add(8'h42, 2'b01); exp_add(8'h43, 2'b01); exp_end();
        @(posedge clk); #1;
        q0.push_back({1'b0, 8'h41});
        q0.push_back({1'b0, 8'h42});
        q0.push_back({1'b1, 8'h43});
        @(negedge clk);                      // valid rises here
        @(negedge clk);                      // one edge later: granted, in LOAD
        n_cmp++; if (bus.grant !== 2'b01) begin n_bad++; $display("FAIL lat_grant: got %b want 01", bus.grant); end
        n_cmp++; if (bus.req0_ready !== 1'b1 || bus.tx_dv !== 1'b0) begin n_bad++; $display("FAIL lat_load: ready %b dv %b want 1 0", bus.req0_ready, bus.tx_dv); end
        @(negedge clk);                      // two edges later: strobe
        n_cmp++; if (bus.tx_dv !== 1'b1 || bus.tx_byte !== 8'h41) begin n_bad++; $display("FAIL lat_strobe: dv %b byte %h want 1 41", bus.tx_dv, bus.tx_byte); end
        wait_idle(400, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_timeout: got timeout want completion"); end
        n_cmp++; if (cap_b.size() !== exp_b.size()) begin n_bad++; $display("FAIL single_count: got %0d want %0d", cap_b.size(), exp_b.size()); end
        for (int i = 0; i < exp_b.size() && i < cap_b.size(); i++) begin
            n_cmp++;
            if (cap_b[i] !== exp_b[i] || cap_g[i] !== exp_g[i]) begin
                n_bad++; $display("FAIL single[%0d]: got %h/%b want %h/%b", i, cap_b[i], cap_g[i], exp_b[i], exp_g[i]);
            end
        end
        n_cmp++; if (bus.grant !== 2'b00) begin n_bad++; $display("FAIL single_release: grant %b want 00", bus.grant); end
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        clear_all();
        exp_add(8'h11, 2'b01); exp_add(8'h12, 2'b01); exp_end();
        exp_add(8'h21, 2'b10); exp_add(8'h22, 2'b10); exp_end();
        @(posedge clk); #1;
        q0.push_back({1'b0, 8'h11}); q0.push_back({1'b1, 8'h12});
        q1.push_back({1'b0, 8'h21}); q1.push_back({1'b1, 8'h22});
        wait_idle(600, ok);
        // Second tie: req1 was served last, so req0 wins again.
        exp_add(8'h13, 2'b01); exp_end();
        exp_add(8'h23, 2'b10); exp_end();
        @(posedge clk); #1;
        q0.push_back({1'b1, 8'h13});
        q1.push_back({1'b1, 8'h23});
        wait_idle(600, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rr_timeout: got timeout want completion"); end
        n_cmp++; if (cap_b.size() !== exp_b.size()) begin n_bad++; $display("FAIL rr_count: got %0d want %0d", cap_b.size(), exp_b.size()); end
        for (int i = 0; i < exp_b.size() && i < cap_b.size(); i++) begin
            n_cmp++;
            if (cap_b[i] !== exp_b[i] || cap_g[i] !== exp_g[i]) begin
                n_bad++; $display("FAIL rr[%0d]: got %h/%b want %h/%b", i, cap_b[i], cap_g[i], exp_b[i], exp_g[i]);
            end
        end
    endtask

    task automatic test_max_burst();
        bit ok;
        bit seen;
        clear_all();
        for (int i = 0; i < 32; i++) exp_add(8'(8'h80 + i), 2'b10);
        exp_add(8'h5A, 2'b01); exp_end();
        for (int i = 32; i < 40; i++) exp_add(8'(8'h80 + i), 2'b10);
        exp_end();
        @(posedge clk); #1;
        for (int i = 0; i < 40; i++) q1.push_back({(i == 39), 8'(8'h80 + i)});
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bus.grant === 2'b10) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL burst_grant1: got %b want 10", bus.grant); end
        @(posedge clk); #1;
        q0.push_back({1'b1, 8'h5A});
        wait_idle(3000, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL burst_timeout: got timeout want completion"); end
        n_cmp++; if (cap_b.size() !== exp_b.size()) begin n_bad++; $display("FAIL burst_count: got %0d want %0d", cap_b.size(), exp_b.size()); end
        for (int i = 0; i < exp_b.size() && i < cap_b.size(); i++) begin
            n_cmp++;
            if (cap_b[i] !== exp_b[i] || cap_g[i] !== exp_g[i]) begin
                n_bad++; $display("FAIL burst[%0d]: got %h/%b want %h/%b", i, cap_b[i], cap_g[i], exp_b[i], exp_g[i]);
            end
        end
    endtask

    task automatic test_reset_mid_msg();
        bit ok;
        clear_all();
        @(posedge clk); #1;
        q0.push_back({1'b0, 8'h61}); q0.push_back({1'b0, 8'h62});
        q0.push_back({1'b0, 8'h63}); q0.push_back({1'b1, 8'h64});
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (cap_b.size() == 2 && uart_rdy === 1'b0) ok = 1'b1;
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rstmid_reach: got timeout want byte 2 in flight"); end
        repeat (2) @(negedge clk);           // now in WAIT_IDLE of byte 2
        #1 rst_n = 1'b0;
        q0.delete();
        #1;
        n_cmp++; if (bus.tx_dv !== 1'b0 || bus.grant !== 2'b00 || bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_async: dv %b grant %b busy %b want 0 00 0", bus.tx_dv, bus.grant, bus.busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        n_cmp++; if (cap_b.size() !== 2) begin n_bad++; $display("FAIL rstmid_no_strobe: got %0d strobes want 2", cap_b.size()); end
        // First grant on the first edge after reset release.
        @(negedge clk);
        rst_n = 1'b0;
        q0.push_back({1'b1, 8'h70});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.grant !== 2'b01) begin n_bad++; $display("FAIL rst_first_grant: got %b want 01", bus.grant); end
        exp_add(8'h61, 2'b01); exp_add(8'h62, 2'b01); exp_add(8'h70, 2'b01); exp_end();
        wait_idle(400, ok);
        n_cmp++; if (cap_b.size() !== exp_b.size()) begin n_bad++; $display("FAIL rstmid_count: got %0d want %0d", cap_b.size(), exp_b.size()); end
        for (int i = 0; i < exp_b.size() && i < cap_b.size(); i++) begin
            n_cmp++;
            if (cap_b[i] !== exp_b[i]) begin
                n_bad++; $display("FAIL rstmid[%0d]: got %h want %h", i, cap_b[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_tx_ready_block();
        bit ok;
        bit bad;
        clear_all();
        exp_add(8'h55, 2'b01); exp_end();
        @(posedge clk); #1;
        hold_low = 1'b1;
        q0.push_back({1'b1, 8'h55});
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.grant !== 2'b00 || bus.tx_dv !== 1'b0) bad = 1'b1;
        end
        n_cmp++; if (bad) begin n_bad++; $display("FAIL block_no_grant: got grant/strobe while blocked want none"); end
        @(posedge clk); #1;
        hold_low = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (bus.grant !== 2'b01) begin n_bad++; $display("FAIL block_grant_after: got %b want 01", bus.grant); end
        wait_idle(400, ok);
        n_cmp++; if (cap_b.size() !== exp_b.size()) begin n_bad++; $display("FAIL block_count: got %0d want %0d", cap_b.size(), exp_b.size()); end
        for (int i = 0; i < exp_b.size() && i < cap_b.size(); i++) begin
            n_cmp++;
            if (cap_b[i] !== exp_b[i]) begin
                n_bad++; $display("FAIL block[%0d]: got %h want %h", i, cap_b[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_crlf();
        bit ok;
        clear_all();
        exp_add(8'h37, 2'b01); exp_end();
        @(posedge clk); #1;
        q0.push_back({1'b1, 8'h37});
        wait_idle(400, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL crlf_timeout: got timeout want completion"); end
        n_cmp++; if (cap_b.size() !== exp_b.size()) begin n_bad++; $display("FAIL crlf_count: got %0d want %0d", cap_b.size(), exp_b.size()); end
        for (int i = 0; i < exp_b.size() && i < cap_b.size(); i++) begin
            n_cmp++;
            if (cap_b[i] !== exp_b[i] || cap_g[i] !== exp_g[i]) begin
                n_bad++; $display("FAIL crlf[%0d]: got %h/%b want %h/%b", i, cap_b[i], cap_g[i], exp_b[i], exp_g[i]);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        hold_low = 1'b0;
        test_reset();
        test_single_msg();
        test_round_robin();
        test_max_burst();
        test_reset_mid_msg();
        test_tx_ready_block();
        test_crlf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
